// File: rtl/mult_arb_pkg.sv
// Shared state encoding, parameter defaults and pointer sizing for mult_arbiter.
// MULT_ARB_TIMEOUT_EN (consumed by the top) enables the WAIT watchdog.
package mult_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int W_DEF       = 4;
  localparam int TIMEOUT_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic int ptr_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
// Produces a one-hot grant plus its binary index; gnt_any flags a valid pick.
module rr_picker
  import mult_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int PW    = ptr_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic             gnt_any,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [PW-1:0]    gnt_idx
);

  int j;

  always_comb begin
    gnt_any = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    j       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!gnt_any && req[j]) begin
        gnt_any    = 1'b1;
        gnt_oh[j]  = 1'b1;
        gnt_idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one start/done multiplier among N_REQ requesters.
// Define MULT_ARB_TIMEOUT_EN to add a WAIT watchdog that returns a zero product with err.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [2*W-1:0]     rsp_product,
  output logic               busy,
  output logic               err,
  output logic               mul_start,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic [2*W-1:0]     mul_product,
  input  logic               mul_done
);

  localparam int PW = ptr_width(N_REQ);

  if (N_REQ < 2 || TIMEOUT < 1) begin : g_param_check
    $error("mult_arbiter: N_REQ must be >= 2 and TIMEOUT >= 1");
  end

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    id_q, id_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic             mul_start_q, mul_start_d;
  logic [2*W-1:0]   rsp_product_q, rsp_product_d;
  logic [W-1:0]     mul_a_q, mul_a_d;
  logic [W-1:0]     mul_b_q, mul_b_d;
  logic             done_q, done_d;

  logic             pick_any;
  logic [N_REQ-1:0] pick_oh;
  logic [PW-1:0]    pick_idx;
  logic             done_rise;
  logic [N_REQ-1:0] id_oh;
  logic [PW-1:0]    ptr_next;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  rr_picker #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_picker (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_any (pick_any),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx)
  );

  // A done level left over from the previous operation must not count as completion.
  assign done_rise = mul_done & ~done_q;
  assign id_oh     = N_REQ'(1) << id_q;
  assign ptr_next  = (id_q == PW'(N_REQ - 1)) ? '0 : id_q + PW'(1);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    gnt_d         = '0;
    rsp_valid_d   = '0;
    mul_start_d   = 1'b0;
    rsp_product_d = rsp_product_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    done_d        = mul_done;
`ifdef MULT_ARB_TIMEOUT_EN
    err_d         = 1'b0;
    cnt_d         = (state_q == ST_WAIT) ? cnt_q + CW'(1) : '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_oh;
          id_d    = pick_idx;
          mul_a_d = req_a[int'(pick_idx)*W +: W];
          mul_b_d = req_b[int'(pick_idx)*W +: W];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mul_start_d = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_rise) begin
          rsp_product_d = mul_product;
          state_d       = ST_RESP;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d         = 1'b1;
          rsp_product_d = '0;
          rsp_valid_d   = id_oh;
          ptr_d         = ptr_next;
          state_d       = ST_IDLE;
        end
`endif
      end
      ST_RESP: begin
        rsp_valid_d = id_oh;
        ptr_d       = ptr_next;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      id_q          <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      mul_start_q   <= 1'b0;
      rsp_product_q <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      id_q          <= id_d;
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      mul_start_q   <= mul_start_d;
      rsp_product_q <= rsp_product_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      done_q        <= done_d;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_product = rsp_product_q;
  assign mul_start   = mul_start_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized bench for mult_arbiter: behavioural multiplier plus per-requester op queues
// and a round-robin reference model checked on every gnt / mul_start / rsp_valid.
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int TO = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_a, req_b;
  logic [N-1:0]     gnt, rsp_valid;
  logic [2*W-1:0]   rsp_product;
  logic             busy, err, mul_start;
  logic [W-1:0]     mul_a, mul_b;
  logic [2*W-1:0]   mul_product;
  logic             mul_done;

  always #5 clk = ~clk;

  mult_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_a       (req_a),
    .req_b       (req_b),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_product (rsp_product),
    .busy        (busy),
    .err         (err),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .mul_done    (mul_done)
  );

  // Behavioural sequential multiplier: start latches operands, acceptance (acc cycles
  // later) drops done, lat cycles after that done rises with the new product.
  int             lat = 2, acc = 0;
  bit             hang = 1'b0;
  logic           m_done, m_busy, m_pend;
  logic [2*W-1:0] m_prod;
  logic [W-1:0]   m_a, m_b;
  int             m_cnt, m_pcnt;

  always @(posedge clk) begin
    if (reset) begin
      m_done <= 1'b0; m_busy <= 1'b0; m_pend <= 1'b0; m_prod <= '0; m_cnt <= 0; m_pcnt <= 0;
    end else if (mul_start) begin
      m_pend <= 1'b1; m_pcnt <= acc; m_a <= mul_a; m_b <= mul_b;
    end else if (m_pend) begin
      if (m_pcnt == 0) begin
        m_pend <= 1'b0; m_done <= 1'b0; m_busy <= 1'b1; m_cnt <= lat;
      end else m_pcnt <= m_pcnt - 1;
    end else if (m_busy && !hang) begin
      if (m_cnt == 0) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_prod <= m_a * m_b;
      end else m_cnt <= m_cnt - 1;
    end
  end

  assign mul_done    = m_done;
  assign mul_product = m_prod;

  // Reference state
  logic [W-1:0] qa [N][64];
  logic [W-1:0] qb [N][64];
  int           qh [N];
  int           qt [N];
  int           glog [$];
  int           n_chk = 0, n_fail = 0;
  int           cyc = 0, ptr_m = 0, n_gnt = 0, n_rsp = 0, n_push = 0;
  int           in_id = 0, gnt_cyc = 0, start_cyc = 0, rise_cyc = 0;
  logic [W-1:0] in_a, in_b;
  bit           inflight = 1'b0, issued = 1'b0, mon_en = 1'b0, done_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0 && i < N) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int first_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (qh[i] != qt[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int r, input int a, input int b);
    qa[r][qt[r] % 64] = W'(a);
    qb[r][qt[r] % 64] = W'(b);
    qt[r]++;
    n_push++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]          = (qh[i] != qt[i]);
      req_a[i*W +: W] = qa[i][qh[i] % 64];
      req_b[i*W +: W] = qb[i][qh[i] % 64];
    end
  endtask

  task automatic monitor();
    int gi;
    if (gnt != '0) begin
      gi = pick(req, ptr_m);
      check("gnt_onehot", gnt, onehot(gi));
      check("gnt_when_free", inflight, 0);
      glog.push_back(first_set(gnt));
      if (gi >= 0) begin
        in_id = gi; in_a = qa[gi][qh[gi] % 64]; in_b = qb[gi][qh[gi] % 64]; qh[gi]++;
      end
      inflight = 1'b1; issued = 1'b0; gnt_cyc = cyc; start_cyc = -1000; rise_cyc = -1000;
      n_gnt++;
    end
    if (mul_start) begin
      check("start_once", inflight && !issued, 1);
      check("start_lat", cyc - gnt_cyc, 1);
      check("mul_a", mul_a, in_a);
      check("mul_b", mul_b, in_b);
      issued = 1'b1; start_cyc = cyc;
    end
    if (issued && rise_cyc < 0 && mul_done && !done_prev) rise_cyc = cyc;
    if (rsp_valid != '0) begin
      check("rsp_expected", inflight && issued, 1);
      check("rsp_onehot", rsp_valid, onehot(in_id));
      if (hang) begin
        check("to_product", rsp_product, 0);
        check("to_err", err, 1);
        check("to_lat", cyc - start_cyc, TO);
      end else begin
        check("product", rsp_product, int'(in_a) * int'(in_b));
        check("rsp_err", err, 0);
        check("rsp_lat", cyc - rise_cyc, 2);
      end
      ptr_m = (in_id + 1) % N; inflight = 1'b0; issued = 1'b0; n_rsp++;
    end else if (err) begin
      check("err_alone", err, 0);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (mon_en) monitor();
    done_prev = mul_done;
    drive();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; mon_en = 1'b0;
    for (int i = 0; i < N; i++) begin qh[i] = 0; qt[i] = 0; end
    inflight = 1'b0; issued = 1'b0; hang = 1'b0; ptr_m = 0;
    drive();
    repeat (n) cycle();
    reset = 1'b0; mon_en = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (!(queues_empty() && !inflight && !busy) && n < budget) begin
      cycle();
      n++;
    end
    check(tag, n < budget, 1);
  endtask

  task automatic check_zero(input string p);
    check({p, "_gnt"}, gnt, 0);
    check({p, "_rsp_valid"}, rsp_valid, 0);
    check({p, "_mul_start"}, mul_start, 0);
    check({p, "_err"}, err, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_rsp_product"}, rsp_product, 0);
    check({p, "_mul_a"}, mul_a, 0);
    check({p, "_mul_b"}, mul_b, 0);
  endtask

  initial begin
    int base_g, base_r, base_p, n;
    reset = 1'b1; req = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) begin qh[i] = 0; qt[i] = 0; end
    do_reset(3);
    check_zero("reset");

    // Single request
    base_g = n_gnt; base_r = n_rsp;
    push(0, 3, 5);
    wait_idle("single_wait", 200);
    check("single_gnts", n_gnt - base_g, 1);
    check("single_rsps", n_rsp - base_r, 1);

    // All four at once from a fresh pointer
    do_reset(2);
    glog.delete();
    push(0, 15, 15); push(1, 0, 7); push(2, 9, 2); push(3, 4, 4);
    wait_idle("all4_wait", 400);
    check("all4_count", glog.size(), 4);
    for (int k = 0; k < 4 && k < glog.size(); k++) check("all4_order", glog[k], k);

    // Fairness: requesters 0 and 2 held high continuously
    glog.delete();
    for (int k = 0; k < 5; k++) begin
      push(0, $urandom_range(0, 15), $urandom_range(0, 15));
      push(2, $urandom_range(0, 15), $urandom_range(0, 15));
    end
    wait_idle("fair_wait", 800);
    check("fair_count", glog.size(), 10);
    for (int k = 0; k < glog.size(); k++) check("fair_order", glog[k], (k % 2) * 2);

    // Stale done: multiplier accepts the start late, done stays high into WAIT
    acc = 4;
    push(1, 7, 9); push(1, 2, 3);
    wait_idle("stale_wait", 300);
    acc = 0;

    // Randomized traffic
    base_r = n_rsp; base_p = n_push;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(0, N - 1);
        if (qt[n] - qh[n] < 60) push(n, $urandom_range(0, 15), $urandom_range(0, 15));
      end
      lat = $urandom_range(0, 6);
      acc = $urandom_range(0, 2);
      cycle();
    end
    wait_idle("rand_wait", 3000);
    check("rand_rsps", n_rsp - base_r, n_push - base_p);
    lat = 6; acc = 0;

    // Reset during WAIT, then 1010 must grant bit 1
    push(2, 6, 7);
    wait_idle("pre_rst_wait", 200);
    push(2, 5, 5);
    n = 0;
    while (!issued && n < 100) begin cycle(); n++; end
    check("reach_wait", issued, 1);
    cycle(); cycle();
    check("in_wait_busy", busy, 1);
    do_reset(1);
    check_zero("midrst");
    glog.delete();
    push(1, 3, 3); push(3, 2, 2);
    wait_idle("post_rst_wait", 300);
    check("post_rst_count", glog.size(), 2);
    if (glog.size() > 0) check("post_rst_first", glog[0], 1);

    // Watchdog: multiplier never completes
    lat = 2; acc = 0;
    hang = 1'b1;
    base_r = n_rsp;
    push(3, 9, 9);
`ifdef MULT_ARB_TIMEOUT_EN
    wait_idle("timeout_wait", 200);
    check("timeout_rsps", n_rsp - base_r, 1);
`else
    repeat (100) cycle();
    check("hang_busy", busy, 1);
    check("hang_err", err, 0);
    check("hang_rsps", n_rsp - base_r, 0);
`endif
    do_reset(2);
    check_zero("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
